// File: rtl/amp_level_sequencer.sv
// Amplitude level sequencer.
// Chooses the attenuation code for the waveform amplitude selector. The code comes either from
// manual up/down buttons or from an automatic ping-pong sweep. A new level is staged in `target`
// and copied to `amp_sel` only on a period_start strobe, so the output never steps mid-cycle.
module amp_level_sequencer #(
  parameter int unsigned HOLD_TICKS = 256  // sample ticks per sweep level, 1..65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       period_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       sweep_en,
  output logic [1:0] amp_sel,
  output logic       pending,
  output logic       applied
);

  localparam logic [15:0] CntLast = 16'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    StManualIdle,
    StManualPend,
    StSweepCount,
    StSweepPend
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  target_q, target_d;
  logic [1:0]  amp_sel_q, amp_sel_d;
  logic        dir_q, dir_d;        // 0: code increasing, 1: code decreasing
  logic [15:0] cnt_q, cnt_d;
  logic        btn_up_q, btn_up_d;
  logic        btn_down_q, btn_down_d;
  logic        applied_q, applied_d;

  logic up_edge;
  logic dn_edge;
  logic in_pend;

  assign up_edge = btn_up & ~btn_up_q;
  assign dn_edge = btn_down & ~btn_down_q;
  assign in_pend = (state_q == StManualPend) || (state_q == StSweepPend);

  // Next-state logic: apply rule first, then per-state target, counter and mode handling.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    amp_sel_d  = amp_sel_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    applied_d  = 1'b0;
    btn_up_d   = btn_up;
    btn_down_d = btn_down;

    // A staged level is committed only at a period boundary. The sweep turns around at the ends.
    if (in_pend && period_start) begin
      amp_sel_d = target_q;
      applied_d = 1'b1;
      if (target_q == 2'd3) begin
        dir_d = 1'b1;
      end else if (target_q == 2'd0) begin
        dir_d = 1'b0;
      end
    end

    unique case (state_q)
      StManualIdle, StManualPend: begin
        // Simultaneous edges cancel. Edges accumulate on target while a change is pending.
        if (up_edge && !dn_edge) begin
          target_d = (target_q == 2'd0) ? 2'd0 : target_q - 2'd1;
        end else if (dn_edge && !up_edge) begin
          target_d = (target_q == 2'd3) ? 2'd3 : target_q + 2'd1;
        end

        if (sweep_en) begin
          // Entering sweep: restart the hold count and head away from the end we sit at.
          cnt_d   = 16'd0;
          dir_d   = (amp_sel_d == 2'd3);
          state_d = (target_d != amp_sel_d) ? StSweepPend : StSweepCount;
        end else begin
          // Returning target to amp_sel cancels the request without an apply.
          state_d = (target_d != amp_sel_d) ? StManualPend : StManualIdle;
        end
      end

      StSweepCount: begin
        if (!sweep_en) begin
          cnt_d   = 16'd0;
          state_d = StManualIdle;
        end else if (sample_tick) begin
          if (cnt_q == CntLast) begin
            // The step is only staged here. A coincident period_start does not apply it.
            cnt_d    = 16'd0;
            target_d = dir_q ? (amp_sel_q - 2'd1) : (amp_sel_q + 2'd1);
            state_d  = StSweepPend;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      StSweepPend: begin
        // The counter holds here. Ticks seen while waiting for the boundary are dropped.
        if (!sweep_en) begin
          cnt_d   = 16'd0;
          state_d = (target_d != amp_sel_d) ? StManualPend : StManualIdle;
        end else if (period_start) begin
          state_d = StSweepCount;
        end
      end

      default: begin
        state_d = StManualIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset. A pending change is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StManualIdle;
      target_q   <= 2'd0;
      amp_sel_q  <= 2'd0;
      dir_q      <= 1'b0;
      cnt_q      <= 16'd0;
      // Resetting the edge detectors high means a button held through reset makes no edge.
      btn_up_q   <= 1'b1;
      btn_down_q <= 1'b1;
      applied_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      amp_sel_q  <= amp_sel_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      btn_up_q   <= btn_up_d;
      btn_down_q <= btn_down_d;
      applied_q  <= applied_d;
    end
  end

  assign amp_sel = amp_sel_q;
  assign pending = (target_q != amp_sel_q);
  assign applied = applied_q;

endmodule
